// File: rtl/rob_retire_window_if.sv
// Reorder-buffer entry type and the head-window/retire-mask channel
// between the ROB (master, producer) and retire_stage (slave).
package rob_pkg;
    localparam int SYS_XLEN = 32;

    typedef struct packed {
        logic                completed;
        logic                precise_state_need;
        logic [SYS_XLEN-1:0] cs_retire_pc;
        logic [SYS_XLEN-1:0] pc;
        logic [4:0]          dest_areg;
        logic [5:0]          dest_preg;
    } rob_entry_t;
endpackage

interface rob_retire_window_if;
    import rob_pkg::*;

    rob_entry_t [2:0] rob_head_entry;
    logic [2:0]       retire_en;
    logic             squash;

    modport master (
        output rob_head_entry,
        input  retire_en,
        input  squash
    );

    modport slave (
        input  rob_head_entry,
        output retire_en,
        output squash
    );
endinterface

// File: rtl/rob_retire_window.sv
// 3-wide circular reorder buffer: dispatch at tail, registered CDB completion,
// head window to retire_stage, squash recovery. Optional ROB_HWM_EN adds rob_hwm.
module rob_retire_window
    import rob_pkg::*;
#(
    parameter  int ROB_DEPTH = 32,
    parameter  int WAY       = 3,
    localparam int IDX_W     = $clog2(ROB_DEPTH),
    localparam int CNT_W     = IDX_W + 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WAY-1:0]               dis_en,
    input  rob_entry_t [WAY-1:0]         dis_entry,
    output logic [WAY-1:0][IDX_W-1:0]    dis_tag,
    input  logic [WAY-1:0]               cdb_valid,
    input  logic [WAY-1:0][IDX_W-1:0]    cdb_tag,
    input  logic [WAY-1:0]               cdb_mispredict,
    input  logic [WAY-1:0][SYS_XLEN-1:0] cdb_target_pc,
    rob_retire_window_if.master          ret_if,
    output logic [CNT_W-1:0]             rob_free_count,
    output logic                         rob_full
`ifdef ROB_HWM_EN
    ,
    output logic [CNT_W-1:0]             rob_hwm
`endif
);

    rob_entry_t ent_q [ROB_DEPTH];
    rob_entry_t ent_d [ROB_DEPTH];

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // CDB results are staged one cycle before touching the entry array
    logic [WAY-1:0]               cdb_v_q;
    logic [WAY-1:0][IDX_W-1:0]    cdb_tag_q;
    logic [WAY-1:0]               cdb_mis_q;
    logic [WAY-1:0][SYS_XLEN-1:0] cdb_pc_q;

    logic [WAY-1:0]            dis_acc;
    logic [CNT_W-1:0]          dis_cnt;
    logic [CNT_W-1:0]          ret_cnt;
    logic [WAY-1:0][IDX_W-1:0] cdb_off;
    rob_entry_t [WAY-1:0]      head_win;
    logic [WAY-1:0]            head_done;

    assign rob_free_count = CNT_W'(ROB_DEPTH) - count_q;
    assign rob_full       = (count_q == CNT_W'(ROB_DEPTH));

    // Slot k has rank WAY-1-k; acceptance uses the start-of-cycle free count
    always_comb begin
        dis_acc = '0;
        dis_cnt = '0;
        ret_cnt = '0;
        for (int k = 0; k < WAY; k++) begin
            dis_tag[k] = tail_q + IDX_W'(WAY - 1 - k);
            dis_acc[k] = dis_en[k] &&
                         (CNT_W'(WAY - 1 - k) < rob_free_count);
            dis_cnt    = dis_cnt + CNT_W'(dis_acc[k]);
            ret_cnt    = ret_cnt + CNT_W'(ret_if.retire_en[k]);
        end
    end

    always_comb begin
        for (int i = 0; i < WAY; i++) begin
            if (CNT_W'(WAY - 1 - i) < count_q) begin
                head_win[i] = ent_q[head_q + IDX_W'(WAY - 1 - i)];
            end else begin
                head_win[i] = '0;
            end
            head_done[i] = head_win[i].completed;
        end
    end

    assign ret_if.rob_head_entry = head_win;

    always_comb begin
        for (int c = 0; c < WAY; c++) begin
            cdb_off[c] = cdb_tag_q[c] - head_q;
        end
    end

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q + IDX_W'(ret_cnt);
        tail_d  = tail_q + IDX_W'(dis_cnt);
        count_d = count_q + dis_cnt - ret_cnt;

        for (int i = 0; i < WAY; i++) begin
            if (ret_if.retire_en[i]) begin
                ent_d[head_q + IDX_W'(WAY - 1 - i)].completed = 1'b0;
            end
        end

        // Only occupied slots that are not leaving this cycle take a result
        for (int c = 0; c < WAY; c++) begin
            if (cdb_v_q[c] &&
                (CNT_W'(cdb_off[c]) < count_q) &&
                (CNT_W'(cdb_off[c]) >= ret_cnt)) begin
                ent_d[cdb_tag_q[c]].completed = 1'b1;
                if (cdb_mis_q[c]) begin
                    ent_d[cdb_tag_q[c]].precise_state_need = 1'b1;
                    ent_d[cdb_tag_q[c]].cs_retire_pc       = cdb_pc_q[c];
                end
            end
        end

        for (int k = 0; k < WAY; k++) begin
            if (dis_acc[k]) begin
                ent_d[dis_tag[k]]           = dis_entry[k];
                ent_d[dis_tag[k]].completed = 1'b0;
            end
        end

        if (ret_if.squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            for (int e = 0; e < ROB_DEPTH; e++) begin
                ent_d[e].completed          = 1'b0;
                ent_d[e].precise_state_need = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            cdb_v_q   <= '0;
            cdb_tag_q <= '0;
            cdb_mis_q <= '0;
            cdb_pc_q  <= '0;
            for (int e = 0; e < ROB_DEPTH; e++) begin
                ent_q[e] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            cdb_v_q   <= ret_if.squash ? '0 : cdb_valid;
            cdb_tag_q <= cdb_tag;
            cdb_mis_q <= cdb_mispredict;
            cdb_pc_q  <= cdb_target_pc;
            for (int e = 0; e < ROB_DEPTH; e++) begin
                ent_q[e] <= ent_d[e];
            end
        end
    end

`ifdef ROB_HWM_EN
    logic [CNT_W-1:0] hwm_q, hwm_d;

    assign hwm_d   = (count_d > hwm_q) ? count_d : hwm_q;
    assign rob_hwm = hwm_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end
`endif

    a_dis_left: assert property (@(posedge clock) disable iff (reset)
        dis_en inside {3'b000, 3'b100, 3'b110, 3'b111});

    a_ret_thermo: assert property (@(posedge clock) disable iff (reset)
        ret_if.retire_en inside {3'b000, 3'b100, 3'b110, 3'b111});

    a_ret_done: assert property (@(posedge clock) disable iff (reset)
        (ret_if.retire_en & ~head_done) == '0);

endmodule
